axi_fifo: RTL and testbench
===========================

Name: axi_fifo

Overview:
- Synchronous single-clock FIFO with valid/ready handshaking on both sides.
- Upstream pushes words through vld_in/rdy_in; downstream pops them through vld_out/rdy_out.
- Show-ahead (first-word-fall-through): the head word is always presented on data_out while vld_out is high.
- Used as a generic elastic buffer between pipeline stages; DEPTH may be any value ≥2, including non-powers of two.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 5, number of storage entries; any integer ≥2, no power-of-two requirement.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- vld_in  input  1  upstream valid; a push occurs on a clk edge when vld_in && rdy_in.
- data_in  input  WIDTH  upstream data; sampled on a push.
- rdy_in  output  1  FIFO can accept a word (not full).
- vld_out  output  1  FIFO holds at least one word (not empty).
- data_out  output  WIDTH  head-of-queue word, valid while vld_out=1.
- rdy_out  input  1  downstream ready; a pop occurs on a clk edge when vld_out && rdy_out.

Behaviour:
- State:
  - mem[DEPTH] of WIDTH bits.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits.
  - count, $clog2(DEPTH+1) bits.
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Consequently vld_out=0 and rdy_in=1 while reset is held. mem is not reset.
- Outputs are combinational from registered state:
  - rdy_in = (count != DEPTH)
  - vld_out = (count != 0)
  - data_out = mem[rd_ptr]
  - No output depends combinationally on vld_in or rdy_out.
- When empty, data_out shows stale contents; downstream must ignore it.
- Push: mem[wr_ptr] <= data_in; wr_ptr advances.
- Pop: rd_ptr advances.
- Pointer wrap: the increment is ptr==DEPTH-1 ? 0 : ptr+1, which is correct for non-power-of-two DEPTH.
- Count update: push only +1; pop only −1; simultaneous push and pop leaves count unchanged, and both pointers advance.
- Latency: a word pushed at edge N is on data_out with vld_out=1 immediately after edge N if the FIFO was empty. There is no combinational bypass from data_in to data_out.
- Full: rdy_in=0, and vld_in is ignored. Full plus pop in the same cycle accepts no push, because rdy_in is derived from registered count. The push is accepted the next cycle.
- Empty: vld_out=0, and rdy_out is ignored; no pointer movement, no underflow.
- Ordering is strictly first-in, first-out. No word is lost or duplicated.
- vld_in may drop without a handshake completing; the FIFO imposes no stability requirement on the upstream side.
- Reset asserted mid-operation discards all contents immediately.

Optional Feature:
- Macro: AXI_FIFO_ASSERT_EN.
- Defined: simulation-only concurrent assertions are compiled in, disabled while rst_n=0:
  - count ≤ DEPTH.
  - count equals the pointer distance, modulo DEPTH, whenever 0 < count < DEPTH.
  - No push is accepted while full.
  - No pop is accepted while empty.
  - data_in has no X/Z when a push occurs.
  - Failures report via $error.
- Undefined: no assertion logic; RTL function is identical.

Decomposition:
- Shared package axi_fifo_pkg:
  - Function ptr_inc(ptr, depth), implementing the wrap increment.
  - Localparam helpers for pointer and count widths, $clog2(DEPTH) and $clog2(DEPTH+1).
- One natural sub-module, axi_fifo_mem:
  - WIDTH×DEPTH register array with one write port (we, waddr, wdata).
  - One asynchronous read port (raddr → rdata).
- Control (pointers, count, flags) stays in axi_fifo.

Test Plan:
- Reset, then push 5 random 64-bit words with WIDTH=64, DEPTH=5 → rdy_in=0 after the 5th push. Pop 5 → data_out matches push order before each pop; vld_out=0 after the last.
- WIDTH=8, DEPTH=4: push 4 words, then present 8'hFF with vld_in=1 → rdy_in stays 0 and 8'hFF is never output. Next 4 pops return the original 4 words in order.
- WIDTH=16, DEPTH=8: fill 8, drain 8 → in-order data, then vld_out=0. Pulse rdy_out=1 while empty → vld_out stays 0 and the pointers are unchanged.
- DEPTH=5: push 3, pop 2, push 4 (pointer wraps past 4→0), pop 5 → the remaining 5 words come out in order.
- Hold vld_in=1 and rdy_out=1 continuously with half-full occupancy → one word in and one out per cycle, count constant, data in order. Then assert rst_n=0 mid-stream → vld_out=0 and rdy_in=1 asynchronously.

Source files
------------

// File: rtl/axi_fifo_pkg.sv
// Shared helpers for axi_fifo: pointer/count width functions and the
// wrap-around pointer increment used by both FIFO pointers.
package axi_fifo_pkg;

    // Pointer width for a given depth; depth >= 2 always yields at least 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width must be able to represent the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage : axi_fifo_pkg

// File: rtl/axi_fifo_mem.sv
// Storage array for axi_fifo: one synchronous write port and one
// asynchronous read port so the head word is visible without latency.
module axi_fifo_mem
    import axi_fifo_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 5,
    parameter int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the data array has no reset; validity is tracked by count in the
    // control logic, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : axi_fifo_mem

// File: rtl/axi_fifo.sv
// Single-clock show-ahead FIFO with valid/ready on both sides.
// Define AXI_FIFO_ASSERT_EN to compile in simulation-only protocol assertions.
module axi_fifo
    import axi_fifo_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             rdy_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             rdy_out
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push, pop;

    // Flags come only from registered count, so a full FIFO refuses a push
    // even when a pop happens in the same cycle.
    assign rdy_in  = (count_q != CNT_FULL);
    assign vld_out = (count_q != '0);
    assign push    = vld_in  && rdy_in;
    assign pop     = vld_out && rdy_out;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    axi_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

`ifdef AXI_FIFO_ASSERT_EN
    int unsigned ptr_dist;
    assign ptr_dist = (32'(wr_ptr_q) + 32'(DEPTH) - 32'(rd_ptr_q)) % 32'(DEPTH);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_FULL)
        else $error("axi_fifo: count %0d exceeds depth %0d", count_q, DEPTH);

    a_ptr_dist: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q != '0 && count_q != CNT_FULL) |-> (32'(count_q) == ptr_dist))
        else $error("axi_fifo: count %0d disagrees with pointer distance %0d", count_q, ptr_dist);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q == CNT_FULL) |-> !push)
        else $error("axi_fifo: push accepted while full");

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q == '0) |-> !pop)
        else $error("axi_fifo: pop accepted while empty");

    a_data_known: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> !$isunknown(data_in))
        else $error("axi_fifo: X/Z on data_in during push");
`else
    // Assertions compiled out; datapath and control are unchanged.
`endif

endmodule : axi_fifo

// File: tb/tb_axi_fifo.sv
// Directed bench for axi_fifo: three instances (64x5, 8x4, 16x8) share
// one stimulus path, selected by sel, and are checked against fixed vectors.
module tb_axi_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        vld = 1'b0;
    logic        rdy = 1'b0;
    logic [63:0] din = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic        a_rdy_in, a_vld_out, b_rdy_in, b_vld_out, c_rdy_in, c_vld_out;
    logic [63:0] a_dout;
    logic [7:0]  b_dout;
    logic [15:0] c_dout;

    axi_fifo #(.WIDTH(64), .DEPTH(5)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .vld_in(vld && sel == 2'd0), .data_in(din), .rdy_in(a_rdy_in),
        .vld_out(a_vld_out), .data_out(a_dout), .rdy_out(rdy && sel == 2'd0));

    axi_fifo #(.WIDTH(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .vld_in(vld && sel == 2'd1), .data_in(din[7:0]), .rdy_in(b_rdy_in),
        .vld_out(b_vld_out), .data_out(b_dout), .rdy_out(rdy && sel == 2'd1));

    axi_fifo #(.WIDTH(16), .DEPTH(8)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .vld_in(vld && sel == 2'd2), .data_in(din[15:0]), .rdy_in(c_rdy_in),
        .vld_out(c_vld_out), .data_out(c_dout), .rdy_out(rdy && sel == 2'd2));

    logic        o_rdy_in, o_vld_out;
    logic [63:0] o_data;

    always_comb begin
        o_rdy_in  = a_rdy_in;
        o_vld_out = a_vld_out;
        o_data    = a_dout;
        case (sel)
            2'd1: begin o_rdy_in = b_rdy_in; o_vld_out = b_vld_out; o_data = {56'd0, b_dout}; end
            2'd2: begin o_rdy_in = c_rdy_in; o_vld_out = c_vld_out; o_data = {48'd0, c_dout}; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with the given handshake inputs; returns #1 after the edge.
    task automatic cycle(input logic v, input logic [63:0] d, input logic r);
        vld = v; din = d; rdy = r;
        @(posedge clk);
        #1;
        vld = 1'b0; rdy = 1'b0;
    endtask

    task automatic push(input logic [63:0] d);
        cycle(1'b1, d, 1'b0);
    endtask

    task automatic pop_expect(input string tag, input logic [63:0] exp);
        check({tag, "_vld"}, {63'd0, o_vld_out}, 64'd1);
        check({tag, "_data"}, o_data, exp);
        cycle(1'b0, '0, 1'b1);
    endtask

    logic [63:0] va [5] = '{64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001,
                            64'hFFFF_0000_FFFF_0000, 64'h8000_0000_0000_0000,
                            64'h0000_0000_0000_0005};
    logic [7:0]  vb [4] = '{8'h11, 8'h22, 8'h00, 8'hA5};
    logic [63:0] q [$];
    logic [63:0] next;

    initial begin
        // Reset state for all three instances
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check($sformatf("rst_vld_%0d", s), {63'd0, o_vld_out}, 64'd0);
            check($sformatf("rst_rdy_%0d", s), {63'd0, o_rdy_in}, 64'd1);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // 64x5: fill, full flag, drain in order
        sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            push(va[i]);
            check($sformatf("a_fill_rdy_%0d", i), {63'd0, o_rdy_in}, (i == 4) ? 64'd0 : 64'd1);
        end
        for (int i = 0; i < 5; i++) pop_expect($sformatf("a_drain_%0d", i), va[i]);
        check("a_empty", {63'd0, o_vld_out}, 64'd0);
        check("a_rdy_after_drain", {63'd0, o_rdy_in}, 64'd1);

        // 8x4: push while full is ignored
        sel = 2'd1;
        for (int i = 0; i < 4; i++) push({56'd0, vb[i]});
        check("b_full", {63'd0, o_rdy_in}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 64'hFF, 1'b0);
            check($sformatf("b_full_hold_%0d", i), {63'd0, o_rdy_in}, 64'd0);
            check($sformatf("b_head_hold_%0d", i), o_data, {56'd0, vb[0]});
        end
        for (int i = 0; i < 4; i++) pop_expect($sformatf("b_drain_%0d", i), {56'd0, vb[i]});
        check("b_empty", {63'd0, o_vld_out}, 64'd0);

        // 16x8: fill, drain, then pop attempts while empty
        sel = 2'd2;
        for (int i = 0; i < 8; i++) push(64'(16'h1000 + 16'(i * 16'h0111)));
        check("c_full", {63'd0, o_rdy_in}, 64'd0);
        for (int i = 0; i < 8; i++)
            pop_expect($sformatf("c_drain_%0d", i), 64'(16'h1000 + 16'(i * 16'h0111)));
        check("c_empty", {63'd0, o_vld_out}, 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        check("c_empty_pop_vld", {63'd0, o_vld_out}, 64'd0);
        check("c_empty_pop_rd", 64'(dut_c.rd_ptr_q), 64'd0);
        check("c_empty_pop_wr", 64'(dut_c.wr_ptr_q), 64'd0);
        push(64'h0000_0000_0000_BEEF);
        pop_expect("c_after_empty", 64'h0000_0000_0000_BEEF);
        check("c_empty2", {63'd0, o_vld_out}, 64'd0);

        // 64x5: push 3, pop 2, push 4 across the wrap, pop 5
        sel = 2'd0;
        for (int i = 0; i < 3; i++) push(64'h100 + 64'(i));
        pop_expect("w_pop_0", 64'h100);
        pop_expect("w_pop_1", 64'h101);
        for (int i = 3; i < 7; i++) push(64'h100 + 64'(i));
        check("w_full", {63'd0, o_rdy_in}, 64'd0);
        for (int i = 2; i < 7; i++) pop_expect($sformatf("w_drain_%0d", i), 64'h100 + 64'(i));
        check("w_empty", {63'd0, o_vld_out}, 64'd0);

        // 64x5: steady streaming at occupancy 2
        push(64'hA0);
        push(64'hA1);
        q.push_back(64'hA0);
        q.push_back(64'hA1);
        next = 64'hA2;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("s_vld_%0d", i), {63'd0, o_vld_out}, 64'd1);
            check($sformatf("s_rdy_%0d", i), {63'd0, o_rdy_in}, 64'd1);
            check($sformatf("s_head_%0d", i), o_data, q[0]);
            check($sformatf("s_cnt_%0d", i), 64'(dut_a.count_q), 64'd2);
            cycle(1'b1, next, 1'b1);
            q.push_back(next);
            void'(q.pop_front());
            next = next + 64'd1;
        end
        check("s_head_final", o_data, q[0]);

        // Asynchronous reset in the middle of the stream
        vld = 1'b1; din = next; rdy = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_vld", {63'd0, o_vld_out}, 64'd0);
        check("rst_async_rdy", {63'd0, o_rdy_in}, 64'd1);
        vld = 1'b0; rdy = 1'b0;
        @(posedge clk); #1;
        check("rst_held_vld", {63'd0, o_vld_out}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_vld", {63'd0, o_vld_out}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_axi_fifo
